// File: rtl/pulser_pkg.sv
`timescale 10ns/1ps
// pulser_pkg
//   Shared definitions for the LED pulse sequencer: FSM state encoding,
//   default field widths and the nominal clock period (in 10 ns units)
//   used when simulating the ~32 MHz system clock.
package pulser_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } state_e;

  localparam int DEF_CNT_W   = 24;
  localparam int DEF_BURST_W = 16;

  localparam real TB_CLK_PERIOD = 3.126;

endpackage

// File: rtl/pulse_down_counter.sv
`timescale 10ns/1ps
// pulse_down_counter
//   Loadable unsigned down-counter that stops at zero. The sequencer
//   reloads it on every phase change and moves on when `zero` is seen.
// Ports:
//   CLK, RST  - clock, asynchronous active-high reset
//   load      - load load_val this edge (has priority over counting)
//   load_val  - value to load
//   zero      - counter currently holds 0
module pulse_down_counter
  import pulser_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_sequencer.sv
`timescale 10ns/1ps
// pulse_sequencer
//   Programmable burst controller driving the LED pin. A START in IDLE
//   latches DELAY/PERIOD/WIDTH/COUNT and plays COUNT pulses of WIDTH high
//   cycles every PERIOD cycles, the first rising edge DELAY+1 edges after
//   the accepting edge.
// Request semantics: START and ABORT are single-cycle requests sampled on
//   the rising CLK edge; there is no ready/acknowledge. START outside IDLE
//   is silently ignored, ABORT outside a burst is ignored, and ABORT beats
//   START when both arrive together.
// Ports:
//   CLK, RST                - clock, asynchronous active-high reset
//   START, ABORT            - launch / cancel a burst
//   DELAY, PERIOD, WIDTH    - timing fields (CNT_W bits, clock cycles)
//   COUNT                   - pulses per burst (BURST_W bits)
//   LED                     - registered pulse output
//   BUSY, DONE, ERR         - burst active / normal completion / rejected START
//   PULSE_IDX               - pulses started in the current or last burst
//   DBG_STATE               - current FSM state for observation
module pulse_sequencer
  import pulser_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               ABORT,
  input  logic [CNT_W-1:0]   DELAY,
  input  logic [CNT_W-1:0]   PERIOD,
  input  logic [CNT_W-1:0]   WIDTH,
  input  logic [BURST_W-1:0] COUNT,
  output logic               LED,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR,
  output logic [BURST_W-1:0] PULSE_IDX,
  output state_e             DBG_STATE
);

  state_e             state;
  logic [CNT_W-1:0]   period_q;
  logic [CNT_W-1:0]   width_q;
  logic [BURST_W-1:0] count_q;

  logic               cfg_ok;
  logic               accept;
  logic               reject;
  logic               last_pulse;
  logic               zero;
  logic               ld;
  logic [CNT_W-1:0]   ld_val;

  assign cfg_ok     = (WIDTH != '0) && (WIDTH < PERIOD) && (COUNT != '0);
  assign accept     = (state == S_IDLE) && START && !ABORT && cfg_ok;
  assign reject     = (state == S_IDLE) && START && !ABORT && !cfg_ok;
  assign last_pulse = (PULSE_IDX == count_q);
  assign DBG_STATE  = state;

  // The counter holds "edges remaining minus one" for the current phase,
  // so a phase of N cycles is loaded with N-1. DELAY is already in that
  // form. Validity guarantees WIDTH>=1 and PERIOD-WIDTH>=1, so neither
  // subtraction can wrap.
  always_comb begin
    ld     = 1'b0;
    ld_val = '0;
    case (state)
      S_IDLE: begin
        ld     = accept;
        ld_val = DELAY;
      end
      S_WAIT: begin
        ld     = zero;
        ld_val = width_q - CNT_W'(1);
      end
      S_HIGH: begin
        ld     = zero;
        ld_val = period_q - width_q - CNT_W'(1);
      end
      S_LOW: begin
        ld     = zero && !last_pulse;
        ld_val = width_q - CNT_W'(1);
      end
      default: begin
        ld     = 1'b0;
        ld_val = '0;
      end
    endcase
  end

  pulse_down_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .load     (ld),
    .load_val (ld_val),
    .zero     (zero)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      LED       <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      PULSE_IDX <= '0;
      period_q  <= '0;
      width_q   <= '0;
      count_q   <= '0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      if (state != S_IDLE && ABORT) begin
        state <= S_IDLE;
        LED   <= 1'b0;
        BUSY  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              state     <= S_WAIT;
              BUSY      <= 1'b1;
              PULSE_IDX <= '0;
              period_q  <= PERIOD;
              width_q   <= WIDTH;
              count_q   <= COUNT;
            end else if (reject) begin
              ERR <= 1'b1;
            end
          end
          S_WAIT: begin
            if (zero) begin
              state     <= S_HIGH;
              LED       <= 1'b1;
              PULSE_IDX <= PULSE_IDX + BURST_W'(1);
            end
          end
          S_HIGH: begin
            if (zero) begin
              state <= S_LOW;
              LED   <= 1'b0;
            end
          end
          S_LOW: begin
            if (zero) begin
              if (last_pulse) begin
                state <= S_IDLE;
                BUSY  <= 1'b0;
                DONE  <= 1'b1;
              end else begin
                state     <= S_HIGH;
                LED       <= 1'b1;
                PULSE_IDX <= PULSE_IDX + BURST_W'(1);
              end
            end
          end
          default: begin
            state <= S_IDLE;
            LED   <= 1'b0;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
`timescale 10ns/1ps
module tb_pulse_sequencer;
  import pulser_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [23:0] delay;
  logic [23:0] period;
  logic [23:0] width;
  logic [15:0] count;
  logic        led;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] pulse_idx;
  state_e      dbg_state;

  always #(TB_CLK_PERIOD / 2.0) clk = ~clk;

  pulse_sequencer dut (
    .CLK       (clk),
    .RST       (rst),
    .START     (start),
    .ABORT     (abort),
    .DELAY     (delay),
    .PERIOD    (period),
    .WIDTH     (width),
    .COUNT     (count),
    .LED       (led),
    .BUSY      (busy),
    .DONE      (done),
    .ERR       (err),
    .PULSE_IDX (pulse_idx),
    .DBG_STATE (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int vectors;
  int miscompares;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Outputs after edge e are derived directly from the burst timing rules:
  // with t = e - (k+1+DELAY), LED is high when t>=0 and t mod PERIOD < WIDTH,
  // PULSE_IDX = t/PERIOD + 1, and the burst ends at t = COUNT*PERIOD.
  longint edge_n;
  bit     m_active;
  longint m_k, m_d, m_p, m_w, m_c;
  longint m_hold;
  bit     exp_led, exp_busy, exp_done, exp_err;
  longint exp_idx;

  task automatic model_reset();
    m_active = 1'b0;
    m_hold   = 0;
    exp_led  = 1'b0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_idx  = 0;
  endtask

  task automatic model_edge(input bit st, input bit ab, input longint d, input longint p,
                            input longint w, input longint c);
    longint t;
    exp_err  = 1'b0;
    exp_done = 1'b0;
    if (m_active) begin
      if (ab) begin
        m_active = 1'b0;
        m_hold   = exp_idx;
      end else if (edge_n == m_k + 1 + m_d + m_c * m_p) begin
        m_active = 1'b0;
        exp_done = 1'b1;
        m_hold   = m_c;
      end
    end else if (st && !ab) begin
      if (w == 0 || w >= p || c == 0) begin
        exp_err = 1'b1;
      end else begin
        m_active = 1'b1;
        m_k = edge_n; m_d = d; m_p = p; m_w = w; m_c = c;
      end
    end
    if (m_active) begin
      exp_busy = 1'b1;
      t = edge_n - (m_k + 1 + m_d);
      if (t < 0) begin
        exp_led = 1'b0;
        exp_idx = 0;
      end else begin
        exp_led = ((t % m_p) < m_w);
        exp_idx = t / m_p + 1;
      end
    end else begin
      exp_busy = 1'b0;
      exp_led  = 1'b0;
      exp_idx  = m_hold;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive, let one rising edge pass, compare at
  // the next falling edge.
  task automatic step(input bit st, input bit ab, input logic [23:0] d, input logic [23:0] p,
                      input logic [23:0] w, input logic [15:0] c);
    start  = st;
    abort  = ab;
    delay  = d;
    period = p;
    width  = w;
    count  = c;
    model_edge(st, ab, longint'(d), longint'(p), longint'(w), longint'(c));
    @(posedge clk);
    @(negedge clk);
    check("led",       64'(led),       64'(exp_led));
    check("busy",      64'(busy),      64'(exp_busy));
    check("done",      64'(done),      64'(exp_done));
    check("err",       64'(err),       64'(exp_err));
    check("pulse_idx", 64'(pulse_idx), 64'(exp_idx));
    edge_n++;
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Idle cycle with scrambled config fields: they must not disturb a burst.
  task automatic step_idle();
    step(1'b0, 1'b0, 24'($urandom_range(0, 255)), 24'($urandom_range(0, 255)),
         24'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));
  endtask

  task automatic run_burst(input logic [23:0] d, input logic [23:0] p, input logic [23:0] w,
                           input logic [15:0] c, input int n_steps,
                           output logic [63:0] lv, output longint done_rel);
    lv = '0;
    done_rel = -1;
    step(1'b1, 1'b0, d, p, w, c);
    for (int i = 1; i < n_steps; i++) begin
      step_idle();
      if (led) lv[i] = 1'b1;
      if (done && done_rel < 0) done_rel = i;
    end
  endtask

  function automatic logic [63:0] led_pattern(input int d, input int p, input int w, input int c);
    logic [63:0] v;
    v = '0;
    for (int n = 0; n < c; n++)
      for (int j = 0; j < w; j++)
        v[1 + d + n * p + j] = 1'b1;
    return v;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit          st;
    bit          ab;
    logic [23:0] d;
    logic [23:0] p;
    logic [23:0] w;
    logic [15:0] c;
    bit          exp_err;
    bit          exp_busy;
  } vec_t;

  vec_t tbl[10];

  // ---------------- main test ----------------
  initial begin
    logic [63:0] lv;
    longint      done_rel;
    longint      rise;
    bit          saw_done;
    bit          found;

    clk = 1'b0; rst = 1'b1; start = 1'b0; abort = 1'b0;
    delay = '0; period = '0; width = '0; count = '0;
    vectors = 0; miscompares = 0; edge_n = 0;
    model_reset();

    tbl[0] = '{1'b1, 1'b0, 24'd0,        24'd10,       24'd10,       16'd1,      1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 24'd0,        24'd10,       24'd3,        16'd0,      1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 24'd0,        24'd10,       24'd0,        16'd2,      1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 24'd0,        24'd10,       24'd11,       16'd2,      1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 24'd2,        24'd10,       24'd3,        16'd4,      1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 24'd2,        24'd10,       24'd3,        16'd4,      1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 24'd2,        24'd10,       24'd3,        16'd4,      1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 24'd0,        24'hFFFFFF,   24'hFFFFFF,   16'd1,      1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 24'hFFFFFF,   24'hFFFFFF,   24'hFFFFFE,   16'hFFFF,   1'b0, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 24'd0,        24'd2,        24'd1,        16'd1,      1'b0, 1'b1};

    // reset values
    repeat (3) @(negedge clk);
    check("rst_led",   64'(led),       64'd0);
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_done",  64'(done),      64'd0);
    check("rst_err",   64'(err),       64'd0);
    check("rst_idx",   64'(pulse_idx), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    rst = 1'b0;

    // table: validity rules, ABORT priority, extreme field values
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].st, tbl[i].ab, tbl[i].d, tbl[i].p, tbl[i].w, tbl[i].c);
      check("tbl_err",  64'(err),  64'(tbl[i].exp_err));
      check("tbl_busy", 64'(busy), 64'(tbl[i].exp_busy));
      if (tbl[i].exp_busy) step(1'b0, 1'b1, 24'd0, 24'd0, 24'd0, 16'd0);
      step_idle();
    end

    // nominal burst
    run_burst(24'd2, 24'd10, 24'd3, 16'd4, 50, lv, done_rel);
    check("nom_led_pattern", lv, led_pattern(2, 10, 3, 4));
    check("nom_done_edge", 64'(done_rel), 64'd43);
    check("nom_idx", 64'(pulse_idx), 64'd4);

    // minimal burst
    run_burst(24'd0, 24'd2, 24'd1, 16'd1, 8, lv, done_rel);
    check("min_led_pattern", lv, 64'h2);
    check("min_done_edge", 64'(done_rel), 64'd3);

    // abort in the second HIGH phase, with a START while busy on the way
    step(1'b1, 1'b0, 24'd2, 24'd10, 24'd3, 16'd4);
    for (int i = 1; i <= 14; i++) begin
      if (i == 5) step(1'b1, 1'b0, 24'd0, 24'd4, 24'd1, 16'd3);
      else if (i == 14) step(1'b0, 1'b1, 24'd2, 24'd10, 24'd3, 16'd4);
      else step_idle();
    end
    check("abort_led",  64'(led),       64'd0);
    check("abort_busy", 64'(busy),      64'd0);
    check("abort_idx",  64'(pulse_idx), 64'd2);
    saw_done = 1'b0;
    for (int i = 0; i < 35; i++) begin
      step_idle();
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 64'(saw_done), 64'd0);
    step(1'b1, 1'b1, 24'd2, 24'd10, 24'd3, 16'd4);
    check("start_abort_idle_busy", 64'(busy), 64'd0);
    check("start_abort_idle_err",  64'(err),  64'd0);

    // asynchronous reset mid-burst
    step(1'b1, 1'b0, 24'd2, 24'd10, 24'd3, 16'd4);
    for (int i = 0; i < 13; i++) step_idle();
    #0.4 rst = 1'b1;
    #0.4;
    check("arst_led",   64'(led),       64'd0);
    check("arst_busy",  64'(busy),      64'd0);
    check("arst_done",  64'(done),      64'd0);
    check("arst_err",   64'(err),       64'd0);
    check("arst_idx",   64'(pulse_idx), 64'd0);
    check("arst_state", 64'(dbg_state), 64'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) step_idle();
    run_burst(24'd2, 24'd10, 24'd3, 16'd4, 50, lv, done_rel);
    check("arst_nom_led_pattern", lv, led_pattern(2, 10, 3, 4));
    check("arst_nom_done_edge", 64'(done_rel), 64'd43);

    // back-to-back: START in the DONE cycle
    step(1'b1, 1'b0, 24'd2, 24'd10, 24'd3, 16'd2);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step_idle();
      if (done) found = 1'b1;
    end
    check("b2b_done_seen", 64'(found), 64'd1);
    step(1'b1, 1'b0, 24'd3, 24'd5, 24'd2, 16'd1);
    check("b2b_accept_busy", 64'(busy), 64'd1);
    rise = -1;
    for (int i = 1; i <= 20; i++) begin
      step_idle();
      if (led && rise < 0) rise = i;
    end
    check("b2b_first_rise", 64'(rise), 64'd4);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int p;
      p = $urandom_range(0, 8);
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0),
           24'($urandom_range(0, 5)), 24'(p), 24'($urandom_range(0, p)),
           16'($urandom_range(0, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
